// File: rtl/pipe_flow_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ev22_pipe_defs
//   Shared definitions for the stage 3/4/5 pipeline records:
//   - bit positions of the one-hot instruction class word (Type),
//   - record widths,
//   - the bubble (NOP) record,
//   - the per-cycle flow action decoded by pipe_flow_ctrl.
// ---------------------------------------------------------------------------
package ev22_pipe_defs;

  localparam int TYPE_W = 7;
  localparam int SELC_W = 6;

  // Bit positions inside a Type word
  typedef enum int {
    WR_READ  = 0,
    WR_WRITE = 1,
    R_READ   = 2,
    R_WRITE  = 3,
    C_READ   = 4,
    C_WRITE  = 5,
    JUMP     = 6
  } type_bit_e;

  localparam logic [TYPE_W-1:0] NOP_TYPE = 7'b000_0000;
  localparam logic [SELC_W-1:0] NOP_SELC = 6'b00_0000;

  // One pipeline stage record
  typedef struct packed {
    logic [TYPE_W-1:0] typ;
    logic [SELC_W-1:0] selc;
  } rec_t;

  localparam rec_t NOP_REC = '{typ: NOP_TYPE, selc: NOP_SELC};

  // What the pipeline does this cycle, highest priority first
  typedef enum logic [1:0] {
    ACT_FREEZE  = 2'd0,
    ACT_HOLD    = 2'd1,
    ACT_SQUASH  = 2'd2,
    ACT_ADVANCE = 2'd3
  } act_e;

  function automatic logic is_jump(input logic [TYPE_W-1:0] t);
    return t[JUMP];
  endfunction

endpackage

// File: rtl/pipe_flow_ctrl_mem_wait.sv
// ---------------------------------------------------------------------------
// pipe_mem_wait
//   Memory-read freeze timer. A read request seen while idle loads a
//   MEM_WAIT-cycle down-counter. MEM_BUSY is high while the counter is
//   non-zero. Requests are ignored while busy. A request in the first idle
//   cycle after a freeze starts the next freeze immediately.
// Ports
//   clk       in  rising-edge clock
//   nreset    in  asynchronous active-low reset
//   MR_REQ    in  memory read start (level)
//   MEM_BUSY  out freeze in progress (registered)
// ---------------------------------------------------------------------------
module pipe_mem_wait #(
  parameter int unsigned MEM_WAIT = 3
) (
  input  logic clk,
  input  logic nreset,
  input  logic MR_REQ,
  output logic MEM_BUSY
);

  localparam logic [3:0] WAIT_LD = 4'(MEM_WAIT);

  logic [3:0] cnt_r;
  logic [3:0] cnt_nxt_s;
  logic       busy_r;

  // Next counter value: count down while busy, otherwise accept a request
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (cnt_r != 4'd0) begin
      cnt_nxt_s = cnt_r - 4'd1;
    end else if (MR_REQ) begin
      cnt_nxt_s = WAIT_LD;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter and busy flag; busy is registered from the next count so it
  // always equals (cnt_r != 0) without a decode on the output path
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_r  <= 4'd0;
      busy_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      busy_r <= (cnt_nxt_s != 4'd0);
    end
  end

  assign MEM_BUSY = busy_r;

endmodule

// File: rtl/pipe_flow_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_flow_ctrl
//   Owns the stage 3/4/5 instruction records (class bits + destination
//   select) and turns the hazard unit's HOLD, taken jumps and memory-read
//   freezes into stage enables, bubbles and a stage-2 squash.
//   Per-cycle priority: memory freeze > HOLD > jump squash > advance.
// Ports
//   clk, nreset          clock, asynchronous active-low reset
//   HOLD                 stall request for stage 2 (combinational input)
//   Type2, SelC2         stage-2 instruction class / destination select
//   MR_REQ               stage-4 memory read start
//   Type3..5, SelC3..5   stage records (registered)
//   EN_PC, EN_IR, EN_EX  PC/stage-1, IR and stage 3-5 register enables
//   SQUASH2              stage-2 instruction discarded this cycle
//   MEM_BUSY             memory freeze in progress
//   STALL_CNT            saturating count of cycles with EN_PC=0
// ---------------------------------------------------------------------------
module pipe_flow_ctrl
  import ev22_pipe_defs::*;
#(
  parameter int unsigned MEM_WAIT = 3,
  parameter int unsigned CNT_W    = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              HOLD,
  input  logic [TYPE_W-1:0] Type2,
  input  logic [SELC_W-1:0] SelC2,
  input  logic              MR_REQ,
  output logic [TYPE_W-1:0] Type3,
  output logic [TYPE_W-1:0] Type4,
  output logic [TYPE_W-1:0] Type5,
  output logic [SELC_W-1:0] SelC3,
  output logic [SELC_W-1:0] SelC4,
  output logic [SELC_W-1:0] SelC5,
  output logic              EN_PC,
  output logic              EN_IR,
  output logic              EN_EX,
  output logic              SQUASH2,
  output logic              MEM_BUSY,
  output logic [CNT_W-1:0]  STALL_CNT
);

  logic       busy_s;
  act_e       act_s;
  rec_t       rec3_r, rec4_r, rec5_r;
  rec_t       rec3_nxt_s, rec4_nxt_s, rec5_nxt_s;
  logic       squash_r, squash_nxt_s;
  logic [CNT_W-1:0] stall_r;

  pipe_mem_wait #(
    .MEM_WAIT (MEM_WAIT)
  ) u_mem_wait (
    .clk      (clk),
    .nreset   (nreset),
    .MR_REQ   (MR_REQ),
    .MEM_BUSY (busy_s)
  );

  // Decode the cycle's action; only HOLD and registered state are used,
  // so nothing here can close a loop through Type3..5 and the hazard unit
  always_comb begin
    if (busy_s) begin
      act_s = ACT_FREEZE;
    end else if (HOLD) begin
      act_s = ACT_HOLD;
    end else if (squash_r) begin
      act_s = ACT_SQUASH;
    end else begin
      act_s = ACT_ADVANCE;
    end
  end

  // Stage enables and squash strobe; all forced low while in reset
  always_comb begin
    EN_PC   = 1'b0;
    EN_IR   = 1'b0;
    EN_EX   = 1'b0;
    SQUASH2 = 1'b0;
    if (!nreset) begin
      EN_PC   = 1'b0;
      EN_IR   = 1'b0;
      EN_EX   = 1'b0;
      SQUASH2 = 1'b0;
    end else begin
      case (act_s)
        ACT_FREEZE: begin
          EN_PC = 1'b0;
          EN_IR = 1'b0;
          EN_EX = 1'b0;
        end
        ACT_HOLD: begin
          EN_PC = 1'b0;
          EN_IR = 1'b0;
          EN_EX = 1'b1;
        end
        ACT_SQUASH: begin
          EN_PC   = 1'b1;
          EN_IR   = 1'b1;
          EN_EX   = 1'b1;
          SQUASH2 = 1'b1;
        end
        ACT_ADVANCE: begin
          EN_PC = 1'b1;
          EN_IR = 1'b1;
          EN_EX = 1'b1;
        end
        default: begin
          EN_PC = 1'b0;
          EN_IR = 1'b0;
          EN_EX = 1'b0;
        end
      endcase
    end
  end

  // Record shift and squash flag next state. A squashed instruction is
  // replaced by a bubble, so a squashed jump can never re-arm the squash.
  always_comb begin
    rec3_nxt_s   = rec3_r;
    rec4_nxt_s   = rec4_r;
    rec5_nxt_s   = rec5_r;
    squash_nxt_s = squash_r;
    case (act_s)
      ACT_FREEZE: begin
        rec3_nxt_s   = rec3_r;
        rec4_nxt_s   = rec4_r;
        rec5_nxt_s   = rec5_r;
        squash_nxt_s = squash_r;
      end
      ACT_HOLD: begin
        rec3_nxt_s = NOP_REC;
        rec4_nxt_s = rec3_r;
        rec5_nxt_s = rec4_r;
      end
      ACT_SQUASH: begin
        rec3_nxt_s   = NOP_REC;
        rec4_nxt_s   = rec3_r;
        rec5_nxt_s   = rec4_r;
        squash_nxt_s = 1'b0;
      end
      ACT_ADVANCE: begin
        rec3_nxt_s   = '{typ: Type2, selc: SelC2};
        rec4_nxt_s   = rec3_r;
        rec5_nxt_s   = rec4_r;
        squash_nxt_s = is_jump(Type2);
      end
      default: begin
        rec3_nxt_s   = rec3_r;
        rec4_nxt_s   = rec4_r;
        rec5_nxt_s   = rec5_r;
        squash_nxt_s = squash_r;
      end
    endcase
  end

  // Stage records and squash flag
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rec3_r   <= NOP_REC;
      rec4_r   <= NOP_REC;
      rec5_r   <= NOP_REC;
      squash_r <= 1'b0;
    end else begin
      rec3_r   <= rec3_nxt_s;
      rec4_r   <= rec4_nxt_s;
      rec5_r   <= rec5_nxt_s;
      squash_r <= squash_nxt_s;
    end
  end

  // Saturating count of cycles in which the PC is not allowed to advance
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      stall_r <= '0;
    end else if (!EN_PC && !(&stall_r)) begin
      stall_r <= stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_r <= stall_r;
    end
  end

  assign Type3     = rec3_r.typ;
  assign Type4     = rec4_r.typ;
  assign Type5     = rec5_r.typ;
  assign SelC3     = rec3_r.selc;
  assign SelC4     = rec4_r.selc;
  assign SelC5     = rec5_r.selc;
  assign MEM_BUSY  = busy_s;
  assign STALL_CNT = stall_r;

endmodule

// File: tb/tb_pipe_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_flow_ctrl
//   Directed bench for pipe_flow_ctrl. A queue-based reference model tracks
//   the pipeline contents, freeze time left, squash state and stall counts;
//   a compare process checks every output on each falling edge. Directed
//   steps add literal expectations at key points. A second instance with a
//   4-bit stall counter covers saturation.
// ---------------------------------------------------------------------------
module tb_pipe_flow_ctrl;

  logic       clk;
  logic       nreset;
  logic       HOLD;
  logic [6:0] Type2;
  logic [5:0] SelC2;
  logic       MR_REQ;

  logic [6:0]  Type3, Type4, Type5;
  logic [5:0]  SelC3, SelC4, SelC5;
  logic        EN_PC, EN_IR, EN_EX, SQUASH2, MEM_BUSY;
  logic [15:0] STALL_CNT;

  logic [6:0]  s_Type3, s_Type4, s_Type5;
  logic [5:0]  s_SelC3, s_SelC4, s_SelC5;
  logic        s_EN_PC, s_EN_IR, s_EN_EX, s_SQUASH2, s_MEM_BUSY;
  logic [3:0]  s_STALL_CNT;

  int n_chk  = 0;
  int n_fail = 0;
  logic chk_on = 1'b0;

  pipe_flow_ctrl #(.MEM_WAIT(3), .CNT_W(16)) dut (
    .clk(clk), .nreset(nreset), .HOLD(HOLD), .Type2(Type2), .SelC2(SelC2),
    .MR_REQ(MR_REQ), .Type3(Type3), .Type4(Type4), .Type5(Type5),
    .SelC3(SelC3), .SelC4(SelC4), .SelC5(SelC5), .EN_PC(EN_PC),
    .EN_IR(EN_IR), .EN_EX(EN_EX), .SQUASH2(SQUASH2), .MEM_BUSY(MEM_BUSY),
    .STALL_CNT(STALL_CNT)
  );

  pipe_flow_ctrl #(.MEM_WAIT(3), .CNT_W(4)) dut_sat (
    .clk(clk), .nreset(nreset), .HOLD(HOLD), .Type2(Type2), .SelC2(SelC2),
    .MR_REQ(MR_REQ), .Type3(s_Type3), .Type4(s_Type4), .Type5(s_Type5),
    .SelC3(s_SelC3), .SelC4(s_SelC4), .SelC5(s_SelC5), .EN_PC(s_EN_PC),
    .EN_IR(s_EN_IR), .EN_EX(s_EN_EX), .SQUASH2(s_SQUASH2),
    .MEM_BUSY(s_MEM_BUSY), .STALL_CNT(s_STALL_CNT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [6:0] typ;
    logic [5:0] selc;
  } mrec_t;

  mrec_t pipe[$];          // pipe[0] = stage 3, pipe[2] = stage 5
  int    m_wait;           // freeze cycles still to go
  logic  m_squash;         // instruction behind a taken jump must die
  int    m_cnt16, m_cnt4;

  function automatic logic m_busy();
    return (m_wait != 0);
  endfunction

  function automatic logic m_pc_en();
    return nreset && !m_busy() && !HOLD;
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      pipe.delete();
      for (int i = 0; i < 3; i++) pipe.push_back('{typ: 7'h00, selc: 6'h00});
      m_wait   <= 0;
      m_squash <= 1'b0;
      m_cnt16  <= 0;
      m_cnt4   <= 0;
    end else begin
      if (!m_pc_en()) begin
        m_cnt16 <= (m_cnt16 == 65535) ? 65535 : m_cnt16 + 1;
        m_cnt4  <= (m_cnt4 == 15) ? 15 : m_cnt4 + 1;
      end
      if (m_busy()) begin
        m_wait <= m_wait - 1;
      end else begin
        if (MR_REQ) m_wait <= 3;
        if (HOLD || m_squash) pipe.push_front('{typ: 7'h00, selc: 6'h00});
        else                  pipe.push_front('{typ: Type2, selc: SelC2});
        void'(pipe.pop_back());
        if (!HOLD) m_squash <= m_squash ? 1'b0 : Type2[6];
      end
    end
  end

  // Compare every output against the model on each falling edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_type3", Type3, pipe[0].typ);
      chk("m_type4", Type4, pipe[1].typ);
      chk("m_type5", Type5, pipe[2].typ);
      chk("m_selc3", SelC3, pipe[0].selc);
      chk("m_selc4", SelC4, pipe[1].selc);
      chk("m_selc5", SelC5, pipe[2].selc);
      chk("m_en_pc", EN_PC, m_pc_en());
      chk("m_en_ir", EN_IR, m_pc_en());
      chk("m_en_ex", EN_EX, nreset && !m_busy());
      chk("m_squash2", SQUASH2, nreset && m_squash && !HOLD && !m_busy());
      chk("m_mem_busy", MEM_BUSY, m_busy());
      chk("m_stall16", STALL_CNT, m_cnt16);
      chk("m_stall4", s_STALL_CNT, m_cnt4);
      chk("m_sat_en_pc", s_EN_PC, m_pc_en());
    end
  end

  // One cycle: drive inputs just after the rising edge, return at falling edge
  task automatic cyc(input logic h, input logic [6:0] t2, input logic [5:0] s2, input logic mr);
    @(posedge clk);
    #1;
    HOLD   = h;
    Type2  = t2;
    SelC2  = s2;
    MR_REQ = mr;
    @(negedge clk);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [5:0] busy_pat;

  initial begin
    nreset = 1'b0;
    HOLD   = 1'b0;
    Type2  = 7'h00;
    SelC2  = 6'h00;
    MR_REQ = 1'b0;
    repeat (2) @(posedge clk);
    chk_on = 1'b1;
    #1 nreset = 1'b1;
    cyc(1'b0, 7'h00, 6'h00, 1'b0);

    // 1. Advance
    cyc(1'b0, 7'h0C, 6'h05, 1'b0);                                   // A
    chk("a_en_pc", EN_PC, 1'b1);
    chk("a_type3", Type3, 7'h00);
    cyc(1'b0, 7'h0C, 6'h05, 1'b0);                                   // B
    chk("b_type3", Type3, 7'h0C);
    cyc(1'b0, 7'h0C, 6'h05, 1'b0);                                   // C
    chk("c_type4", Type4, 7'h0C);

    // 2. HOLD for two cycles
    cyc(1'b1, 7'h04, 6'h03, 1'b0);                                   // D
    chk("d_type5", Type5, 7'h0C);
    chk("d_selc5", SelC5, 6'h05);
    chk("d_en_pc", EN_PC, 1'b0);
    chk("d_en_ir", EN_IR, 1'b0);
    chk("d_en_ex", EN_EX, 1'b1);
    cyc(1'b1, 7'h04, 6'h03, 1'b0);                                   // E
    chk("e_type3", Type3, 7'h00);
    chk("e_type4", Type4, 7'h0C);

    // 3. Jump advancing, then squash of the following instruction
    cyc(1'b0, 7'h40, 6'h11, 1'b0);                                   // F
    chk("f_type3", Type3, 7'h00);
    chk("f_type4", Type4, 7'h00);
    chk("f_type5", Type5, 7'h0C);
    chk("f_stall", STALL_CNT, 16'd2);
    chk("f_squash2", SQUASH2, 1'b0);
    cyc(1'b0, 7'h08, 6'h02, 1'b0);                                   // G
    chk("g_squash2", SQUASH2, 1'b1);
    chk("g_type3", Type3, 7'h40);
    cyc(1'b0, 7'h08, 6'h02, 1'b0);                                   // H
    chk("h_squash2", SQUASH2, 1'b0);
    chk("h_type3", Type3, 7'h00);
    chk("h_type4", Type4, 7'h40);
    // Jump held by HOLD first
    cyc(1'b1, 7'h40, 6'h11, 1'b0);                                   // I
    chk("i_squash2", SQUASH2, 1'b0);
    chk("i_type3", Type3, 7'h08);
    cyc(1'b0, 7'h40, 6'h11, 1'b0);                                   // J
    chk("j_squash2", SQUASH2, 1'b0);
    chk("j_type3", Type3, 7'h00);
    cyc(1'b1, 7'h08, 6'h02, 1'b0);                                   // K
    chk("k_squash2_masked", SQUASH2, 1'b0);
    chk("k_type3", Type3, 7'h40);
    cyc(1'b0, 7'h08, 6'h02, 1'b0);                                   // L
    chk("l_squash2", SQUASH2, 1'b1);
    chk("l_type3", Type3, 7'h00);
    cyc(1'b0, 7'h0C, 6'h05, 1'b0);                                   // M
    chk("m_squash2_clr", SQUASH2, 1'b0);
    chk("m_type3_lit", Type3, 7'h00);

    // 4. Memory freeze, HOLD ignored while busy
    cyc(1'b0, 7'h20, 6'h0A, 1'b1);                                   // N
    chk("n_busy", MEM_BUSY, 1'b0);
    chk("n_type3", Type3, 7'h0C);
    for (int i = 0; i < 3; i++) begin                                // O,P,Q
      cyc(1'b1, 7'h01, 6'h01, 1'b0);
      chk("frz_busy", MEM_BUSY, 1'b1);
      chk("frz_type3", Type3, 7'h20);
      chk("frz_selc3", SelC3, 6'h0A);
      chk("frz_type4", Type4, 7'h0C);
      chk("frz_en_ex", EN_EX, 1'b0);
    end
    // Back-to-back freeze with MR_REQ held: busy pattern 0,1,1,1,0,1
    for (int i = 0; i < 5; i++) begin                                // R..V
      cyc(1'b0, (i == 4) ? 7'h40 : 7'h01, 6'h01, 1'b1);
      busy_pat[i] = MEM_BUSY;
      if (i == 0) begin
        chk("r_stall", STALL_CNT, 16'd7);
        chk("r_type3", Type3, 7'h20);
      end
    end
    @(posedge clk);                                                  // W
    #1;
    MR_REQ = 1'b0;
    busy_pat[5] = MEM_BUSY;
    chk("btb_busy_pattern", busy_pat, 6'b101110);
    chk("w_type3", Type3, 7'h40);
    chk("w_squash2", SQUASH2, 1'b0);

    // 5. Asynchronous reset mid-freeze with squash pending
    nreset = 1'b0;
    #1;
    chk("rst_en_pc", EN_PC, 1'b0);
    chk("rst_en_ir", EN_IR, 1'b0);
    chk("rst_en_ex", EN_EX, 1'b0);
    chk("rst_busy", MEM_BUSY, 1'b0);
    chk("rst_squash2", SQUASH2, 1'b0);
    chk("rst_type3", Type3, 7'h00);
    chk("rst_type4", Type4, 7'h00);
    chk("rst_type5", Type5, 7'h00);
    chk("rst_selc3", SelC3, 6'h00);
    chk("rst_stall", STALL_CNT, 16'd0);
    @(negedge clk);
    @(posedge clk);                                                  // X
    #1;
    nreset = 1'b1;
    Type2  = 7'h0C;
    SelC2  = 6'h05;
    @(negedge clk);
    chk("x_en_pc", EN_PC, 1'b1);
    chk("x_busy", MEM_BUSY, 1'b0);
    chk("x_squash2", SQUASH2, 1'b0);
    cyc(1'b0, 7'h0C, 6'h05, 1'b0);                                   // Y
    chk("y_type3", Type3, 7'h0C);

    // 6. Saturation on the 4-bit counter
    for (int i = 0; i < 20; i++) cyc(1'b1, 7'h04, 6'h03, 1'b0);
    cyc(1'b0, 7'h00, 6'h00, 1'b0);
    chk("sat_stall4", s_STALL_CNT, 4'hF);
    chk("sat_stall16", STALL_CNT, 16'd20);
    cyc(1'b0, 7'h00, 6'h00, 1'b0);

    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
